// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-side signals of the ALU sequencer.
// The master is the requester that also hosts the combinational ALU.
interface alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       funct;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_funct;
  logic [WIDTH-1:0] alu_out;
  logic             alu_flagZ;

  modport master (
    output start, op_a, op_b, funct, alu_out, alu_flagZ,
    input  busy, done, result, zero, alu_a, alu_b, alu_funct
  );

  modport slave (
    input  start, op_a, op_b, funct, alu_out, alu_flagZ,
    output busy, done, result, zero, alu_a, alu_b, alu_funct
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one operation through the external combinational ALU; shifts are
// iterated one bit per pass to build full 0..31-bit shift amounts.
//
// state | meaning
// IDLE  | waiting for start, ALU inputs held at zero
// EXEC  | single ALU pass on latched operands
// SHIFT | one-bit shift pass per cycle, cnt passes remaining
// DONE  | one-cycle completion pulse, start ignored
module alu_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic           clk,
  input logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   opb_r;
  logic [3:0]         fn_r;
  logic [SHAMT_W-1:0] cnt;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   result_r;
  logic               zero_r;
  logic               start_shift;

  assign start_shift = (bus.funct == 4'b0110 || bus.funct == 4'b0111 ||
                        bus.funct == 4'b1000) &&
                       (bus.op_b[SHAMT_W-1:0] != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      work     <= '0;
      opb_r    <= '0;
      fn_r     <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.op_a;
            opb_r  <= bus.op_b;
            fn_r   <= bus.funct;
            cnt    <= bus.op_b[SHAMT_W-1:0];
            busy_r <= 1'b1;
            state  <= start_shift ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          result_r <= bus.alu_out;
          zero_r   <= bus.alu_flagZ;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state    <= DONE;
        end
        SHIFT: begin
          work <= bus.alu_out;
          cnt  <= cnt - SHAMT_W'(1);
          // Exit at cnt==1 so the counter never wraps below zero.
          if (cnt == SHAMT_W'(1)) begin
            result_r <= bus.alu_out;
            zero_r   <= bus.alu_flagZ;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive decoded from registered state; shift passes always use B=1.
  always_comb begin
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_funct = 4'b0000;
    if (state == EXEC) begin
      bus.alu_a     = work;
      bus.alu_b     = opb_r;
      bus.alu_funct = fn_r;
    end else if (state == SHIFT) begin
      bus.alu_a     = work;
      bus.alu_b     = WIDTH'(1);
      bus.alu_funct = fn_r;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.zero   = zero_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural one-bit-shift ALU.
// Expected results are hand-computed constants queued at issue time.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(32)) bus ();

  alu_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational ALU: shifts move by alu_b[0] bits per pass.
  always_comb begin
    case (bus.alu_funct)
      4'b0000: bus.alu_out = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_out = bus.alu_a - bus.alu_b;
      4'b0010: bus.alu_out = bus.alu_a & bus.alu_b;
      4'b0011: bus.alu_out = bus.alu_a | bus.alu_b;
      4'b0100: bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'b0101: bus.alu_out = ~bus.alu_a;
      4'b0110: bus.alu_out = bus.alu_b[0] ? {bus.alu_a[30:0], 1'b0} : bus.alu_a;
      4'b0111: bus.alu_out = bus.alu_b[0] ? {bus.alu_a[31], bus.alu_a[31:1]} : bus.alu_a;
      4'b1000: bus.alu_out = bus.alu_b[0] ? {1'b0, bus.alu_a[31:1]} : bus.alu_a;
      default: bus.alu_out = 32'h0;
    endcase
    bus.alu_flagZ = (bus.alu_out == 32'h0);
  end

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done with empty queue, expected none");
      end else begin
        e = exp_q.pop_front();
        check("result", bus.result, e.res);
        check("zero", {31'h0, bus.zero}, {31'h0, e.z});
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input logic [31:0] er, input logic ez, input int ecyc, input bit shift);
    int cyc;
    int bad_drive;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.funct = f;
    e.res = er;
    e.z   = ez;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    bad_drive = 0;
    while (!bus.done && cyc < 100) begin
      if (bus.busy) begin
        cyc++;
        if (shift) begin
          if (bus.alu_b !== 32'h1 || bus.alu_funct !== f || bus.alu_a === 32'hx) bad_drive++;
        end else begin
          if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_funct !== f) bad_drive++;
        end
      end
      @(negedge clk);
    end
    check($sformatf("busy_cycles_f%0h", f), cyc, ecyc);
    check($sformatf("alu_drive_f%0h", f), bad_drive, 0);
    @(negedge clk);
    check("done_width", {31'h0, bus.done}, 32'h0);
  endtask

  initial begin
    int d0;
    int guard;
    exp_t e;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.funct = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_zero", {31'h0, bus.zero}, 32'h0);

    run_op(32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1, 1'b0);
    run_op(32'd3, 32'd3, 4'b0001, 32'd0, 1'b1, 1, 1'b0);
    run_op(32'hFFFFFFFF, 32'h1234, 4'b1010, 32'd0, 1'b1, 1, 1'b0);
    run_op(32'h0000F0F0, 32'h0000FF00, 4'b0010, 32'h0000F000, 1'b0, 1, 1'b0);
    run_op(32'h0000F0F0, 32'h0000FF00, 4'b0011, 32'h0000FFF0, 1'b0, 1, 1'b0);
    run_op(32'h0000F0F0, 32'h0000FF00, 4'b0100, 32'h00000FF0, 1'b0, 1, 1'b0);
    run_op(32'h00000000, 32'h0, 4'b0101, 32'hFFFFFFFF, 1'b0, 1, 1'b0);
    run_op(32'h00000001, 32'd4, 4'b0110, 32'h00000010, 1'b0, 4, 1'b1);
    run_op(32'h80000000, 32'd31, 4'b0111, 32'hFFFFFFFF, 1'b0, 31, 1'b1);
    run_op(32'h80000000, 32'd33, 4'b1000, 32'h40000000, 1'b0, 1, 1'b1);
    run_op(32'h00001234, 32'd0, 4'b0110, 32'h00001234, 1'b0, 1, 1'b0);
    run_op(32'h80000000, 32'd32, 4'b1000, 32'h80000000, 1'b0, 1, 1'b0);

    // start held through busy and DONE with other operands: ignored
    @(negedge clk);
    d0 = n_done;
    bus.start = 1'b1;
    bus.op_a  = 32'h1;
    bus.op_b  = 32'd4;
    bus.funct = 4'b0110;
    e.res = 32'h10;
    e.z   = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.op_a  = 32'd99;
    bus.op_b  = 32'd2;
    bus.funct = 4'b0000;
    guard = 0;
    while (!bus.done && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("ignore_timeout", {31'h0, bus.done}, 32'h1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignore_done_count", n_done - d0, 1);
    check("ignore_result_hold", bus.result, 32'h10);
    check("ignore_busy", {31'h0, bus.busy}, 32'h0);

    // reset mid-shift aborts with no done
    @(negedge clk);
    d0 = n_done;
    bus.start = 1'b1;
    bus.op_a  = 32'h1;
    bus.op_b  = 32'd20;
    bus.funct = 4'b0110;
    e.res = 32'h00100000;
    e.z   = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    check("abort_done", {31'h0, bus.done}, 32'h0);
    check("abort_result", bus.result, 32'h0);
    check("abort_zero", {31'h0, bus.zero}, 32'h0);
    check("abort_alu_a", bus.alu_a, 32'h0);
    check("abort_alu_b", bus.alu_b, 32'h0);
    check("abort_alu_funct", {28'h0, bus.alu_funct}, 32'h0);
    check("abort_no_done", n_done - d0, 0);

    run_op(32'd1, 32'd1, 4'b0000, 32'd2, 1'b0, 1, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control stage directly upstream of the combinational ALU.
- Accepts one operation per start pulse (operands plus 4-bit funct) and drives the ALU's A/B/funct inputs.
- Captures the ALU result and zero flag into registers.
- Single-bit-per-pass shift ops are iterated to give full 0..31-bit shifts; all other ops complete in one ALU pass.

Parameters:
- WIDTH, 32, datapath width; fixed at 32 to match the ALU.
- SHAMT_W, 5, width of the shift-amount counter (log2 WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-low reset, one clock, sampled on the rising edge of clk
- start  input  1  request; sampled only in IDLE
- op_a  input  32  operand A
- op_b  input  32  operand B; for shifts, op_b[4:0] is the shift amount
- funct  input  4  operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 not, 0110 sla, 0111 sra, 1000 srl, others give 0
- busy  output  1  high in EXEC/SHIFT
- done  output  1  one-cycle completion pulse
- result  output  32  registered final result
- zero  output  1  registered zero flag of final result
- alu_a  output  32  to ALU A
- alu_b  output  32  to ALU B
- alu_funct  output  4  to ALU funct
- alu_out  input  32  from ALU out
- alu_flagZ  input  1  from ALU flagZ

Behaviour:
- Reset (rst=0 at edge):
  - State goes to IDLE; internal work register and counter go to 0.
  - Outputs: busy=0, done=0, result=0, zero=0.
  - Applies from any state; an operation in flight is aborted with no done.
- FSM states: IDLE, EXEC, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - Latch op_a into work, op_b into opb_r, funct into fn_r, op_b[4:0] into cnt.
  - If fn_r is a shift (0110/0111/1000) and op_b[4:0]!=0, go to SHIFT; otherwise go to EXEC.
- EXEC:
  - Drive alu_a=work, alu_b=opb_r, alu_funct=fn_r.
  - At next edge: result<=alu_out, zero<=alu_flagZ, go to DONE.
  - Latency: done high in the cycle after edge k+1.
  - Shift by 0 passes through EXEC with alu_b bit0=0, so the value is unchanged.
- SHIFT:
  - Drive alu_a=work, alu_b=1, alu_funct=fn_r.
  - Each edge: work<=alu_out, cnt<=cnt-1.
  - When cnt==1 at the edge: result<=alu_out, zero<=alu_flagZ, go to DONE.
  - Shift by n (1..31) takes exactly n SHIFT cycles; done is high in the cycle after edge k+n.
  - op_b[31:5] are ignored.
- DONE:
  - done=1 for exactly one cycle, then unconditional return to IDLE.
  - start is ignored in DONE; the earliest next acceptance is the following cycle.
- IDLE/DONE ALU drive: alu_a=0, alu_b=0, alu_funct=0000.
- busy=1 exactly in EXEC and SHIFT. start while busy or in DONE is ignored; no queuing.
- result/zero hold their value until the next completion or reset.
- Undefined funct (1001-1111): handled as EXEC; ALU yields 0, so result=0, zero=1.
- All arithmetic is performed by the ALU; the sequencer does no arithmetic except the 5-bit counter decrement. The counter never wraps because exit occurs at cnt==1.

Test Plan:
- Reset, then start add op_a=5, op_b=7 -> busy for 1 cycle, done pulse one cycle after, result=12, zero=0; done lasts exactly 1 cycle.
- sub op_a=3, op_b=3 -> result=0, zero=1. Then funct=1010 with op_a=0xFFFFFFFF -> result=0, zero=1.
- sla op_a=0x00000001, op_b=4 -> alu_b=1 and alu_funct=0110 for exactly 4 cycles, result=0x00000010. sra op_a=0x80000000, op_b=31 -> 31 busy cycles, result=0xFFFFFFFF.
- srl op_a=0x80000000, op_b=33 (amount 1) -> 1 SHIFT cycle, result=0x40000000. sla op_b=0 -> EXEC path, result=op_a.
- Start pulses while busy and in DONE with different operands -> ignored; the first op's result is unchanged and only one done pulse occurs.
- rst=0 for one edge mid-SHIFT (sla by 20 after 5 cycles) -> next cycle busy=0, done=0, result=0, zero=0, ALU inputs zero; a new add 1+1 then completes normally with result=2.
